// File: rtl/zap_bp_pkg.sv
// Shared encodings and helpers for the 2-bit branch-history predictor.
package zap_bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bp_state_t;

  // Saturating 2-bit counter: taken counts up, not-taken counts down.
  function automatic logic [1:0] bp_next_state(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken && (state != ST)) begin
      nxt = state + 2'b01;
    end else if (!taken && (state != SNT)) begin
      nxt = state - 2'b01;
    end
    return nxt;
  endfunction

  // Caller truncates the result to its index width.
  function automatic logic [31:0] bp_index(input logic [31:0] pc, input int pc_lsb);
    return pc >> pc_lsb;
  endfunction

endpackage

// File: rtl/zap_branch_predict_sat.sv
// Combinational saturating-counter update for the resolve path.
module zap_branch_predict_sat
  import zap_bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  assign next_state = bp_next_state(state, taken);

endmodule

// File: rtl/zap_branch_predict_ctrl.sv
// Branch-history RAM controller: fetch-side read/predict, resolve-side
// counter write-back, and a full-table clear sweep after reset or flush.
module zap_branch_predict_ctrl
  import zap_bp_pkg::*;
#(
  parameter  int NUMBER_OF_ENTRIES = 64,
  parameter  int ENTRY_SIZE        = 2,
  parameter  int PC_LSB            = 2,
  localparam int IDX_W             = $clog2(NUMBER_OF_ENTRIES)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_fetch_valid,
  input  logic [31:0]           i_fetch_pc,
  input  logic                  i_fetch_stall,
  output logic [IDX_W-1:0]      o_rd_addr,
  input  logic [ENTRY_SIZE-1:0] i_rd_data,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  output logic [ENTRY_SIZE-1:0] o_pred_state,
  input  logic                  i_res_valid,
  input  logic [31:0]           i_res_pc,
  input  logic [ENTRY_SIZE-1:0] i_res_state,
  input  logic                  i_res_taken,
  output logic                  o_wr_en,
  output logic [IDX_W-1:0]      o_wr_addr,
  output logic [ENTRY_SIZE-1:0] o_wr_data,
  output logic                  o_busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_ENTRIES - 1);

  // Valid/ready: none. i_fetch_valid and i_res_valid are single-cycle
  // qualifiers sampled every edge; there is no backpressure on either side.

  bp_state_t             state;
  logic [IDX_W-1:0]      clr_cnt;
  logic [IDX_W-1:0]      held_idx;
  logic                  byp;
  logic [ENTRY_SIZE-1:0] byp_data;
  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      res_idx;
  logic [ENTRY_SIZE-1:0] res_next;

  assign fetch_idx = IDX_W'(bp_index(i_fetch_pc, PC_LSB));
  assign res_idx   = IDX_W'(bp_index(i_res_pc, PC_LSB));

  zap_branch_predict_sat u_sat (
    .state      (i_res_state),
    .taken      (i_res_taken),
    .next_state (res_next)
  );

  assign o_rd_addr = i_fetch_stall ? held_idx : fetch_idx;

  // RAM returns pre-write data on a same-address collision, so forward it.
  assign o_pred_state = !o_pred_valid ? SNT : (byp ? byp_data : i_rd_data);
  assign o_pred_taken = o_pred_state[1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= SNT;
      o_pred_valid <= 1'b0;
      o_busy       <= 1'b1;
      held_idx     <= '0;
      byp          <= 1'b0;
      byp_data     <= SNT;
    end else begin
      held_idx <= o_rd_addr;
      byp      <= o_wr_en && (o_wr_addr == o_rd_addr);
      byp_data <= o_wr_data;
      if (i_flush) begin
        state        <= CLEAR;
        clr_cnt      <= '0;
        o_wr_en      <= 1'b0;
        o_pred_valid <= 1'b0;
        o_busy       <= 1'b1;
      end else begin
        case (state)
          CLEAR: begin
            o_wr_en      <= 1'b1;
            o_wr_addr    <= clr_cnt;
            o_wr_data    <= SNT;
            o_pred_valid <= 1'b0;
            o_busy       <= 1'b1;
            clr_cnt      <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
              state <= RUN;
            end
          end
          RUN: begin
            o_wr_en      <= i_res_valid;
            o_wr_addr    <= res_idx;
            o_wr_data    <= res_next;
            o_pred_valid <= i_fetch_valid | i_fetch_stall;
            o_busy       <= 1'b0;
          end
          default: begin
            state <= CLEAR;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/zap_branch_predict_ctrl.md
Name: zap_branch_predict_ctrl

Overview:
Controller for the 2-bit branch-history block RAM in the fetch path.
- Fetch side: turns fetch PCs into RAM read addresses and returns a taken/not-taken prediction one cycle later.
- Resolve side: takes branch outcomes from execute and computes the saturating-counter update, which it writes back to the RAM.
- Sweeps the whole RAM to 2'b00 after reset or flush, so the table never holds stale history.

Parameters:
NUMBER_OF_ENTRIES, 64, RAM depth (power of 2); IDX_W = $clog2(NUMBER_OF_ENTRIES).
ENTRY_SIZE, 2, counter width; fixed at 2.
PC_LSB, 2, lowest PC bit used for the index; index = pc[PC_LSB+IDX_W-1:PC_LSB].

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_flush  in  1  restart clear sweep (single-cycle pulse)
i_fetch_valid  in  1  fetch PC valid
i_fetch_pc  in  32  fetch PC
i_fetch_stall  in  1  fetch held; hold read index
o_rd_addr  out  IDX_W  RAM read address (combinational)
i_rd_data  in  2  RAM read data (registered inside RAM, 1-cycle latency)
o_pred_valid  out  1  prediction valid
o_pred_taken  out  1  predicted taken
o_pred_state  out  2  counter state; fetch carries it down the pipe to resolve
i_res_valid  in  1  branch resolved
i_res_pc  in  32  resolved branch PC
i_res_state  in  2  counter state captured at prediction
i_res_taken  in  1  actual outcome
o_wr_en  out  1  RAM write enable (registered)
o_wr_addr  out  IDX_W  RAM write address (registered)
o_wr_data  out  2  RAM write data (registered)
o_busy  out  1  clear sweep in progress

Behaviour:
- Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = state[1].
- Update rule: taken increments, not-taken decrements, saturating at 11 and 00.
- FSM states are CLEAR and RUN.
  - Reset puts the FSM in CLEAR, with clr_cnt=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_pred_valid=0, o_busy=1, held index=0.
  - CLEAR: each cycle registers o_wr_en=1, o_wr_addr=clr_cnt, o_wr_data=00, then increments clr_cnt. After address N-1 is issued, next state is RUN.
  - Result: o_wr_en is high for exactly N consecutive cycles, and o_busy falls in the first cycle after the last write.
  - i_flush in any state: go to CLEAR with clr_cnt=0. A flush during CLEAR restarts the sweep.
- During CLEAR:
  - o_pred_valid=0.
  - Resolves are dropped.
  - o_rd_addr still tracks fetch.
- Read path, RUN:
  - o_rd_addr = i_fetch_stall ? held_idx : idx(i_fetch_pc).
  - held_idx registers o_rd_addr every cycle.
  - o_pred_valid registers (i_fetch_valid | i_fetch_stall) & RUN & ~i_flush, so a fetch at cycle N gives a prediction in N+1.
  - While stalled, the prediction refreshes every cycle from the held index.
- Write path, RUN: i_res_valid at cycle M gives o_wr_en=1 at M+1, with o_wr_addr=idx(i_res_pc) and o_wr_data=next(i_res_state, i_res_taken).
  - A write is issued even when the state is unchanged (saturated).
  - Otherwise o_wr_en=0.
- Read-after-write bypass: the RAM returns old data when read and write hit the same address on the same edge.
  - At each edge, if o_wr_en and o_wr_addr==o_rd_addr, register byp=1 and byp_data=o_wr_data; otherwise byp=0.
  - o_pred_state = ~o_pred_valid ? 00 : (byp ? byp_data : i_rd_data).
  - o_pred_taken = o_pred_state[1].
- Simultaneous resolve and fetch to the same index: the prediction sees the updated value through the bypass, no stall.
- Back-to-back resolves to the same index: each write uses its own i_res_state. Last write wins; no merge.
- Reset mid-sweep or mid-operation: all registers return to their reset values and a fresh full sweep runs.

Decomposition:
- Package zap_bp_pkg holds:
  - encoding localparams SNT/WNT/WT/ST;
  - function bp_next_state(state, taken);
  - function bp_index(pc) for the PC_LSB/IDX_W slice.
- One sub-module, zap_branch_predict_sat: combinational saturating update, instantiated once on the resolve path.
- The FSM, bypass and pipeline registers stay in the top module.

Test Plan:
- Reset release, N=64 → o_wr_en high 64 cycles, addresses 0..63 in order, data 00, o_busy=0 on cycle 65; resolves injected meanwhile produce no write.
- Fetch pc 0x0000_0104 → o_rd_addr=1; next cycle o_pred_valid=1, o_pred_taken=0, o_pred_state=00.
- Resolve pc 0x104, state 11, taken=1 → o_wr_en, addr 1, data 11. Then state 00, taken=0 → data 00. Then state 01, taken=1 → data 10.
- Resolve pc 0x108 (state 01, taken) so the write of 10 to idx 2 coincides with a fetch of 0x108 → prediction state 10, taken=1 (bypass), not the RAM's stale 01.
- Fetch 0x10C, then stall 3 cycles while fetch pc changes to 0x200 → o_rd_addr stays 3; pred_valid held high; a resolve write to idx 3 during the stall is visible the following cycle.
- i_flush at sweep address 30 → sweep restarts at 0 and runs 64 more writes. Async i_reset asserted mid-RUN → outputs drop to reset values immediately, a full sweep follows, and predictions read 00.
